// File: rtl/inpkt_dispatch_ctrl_pkg.sv
// Shared constants and types for the input packet dispatch controller.
// The packet-type limit is the same constant the header parser is built with.

`ifndef INPKT_MSB_DEFINED
`define INPKT_MSB_DEFINED
// Index of the most significant bit needed to hold the value x.
`define MSB(x) ($clog2((x) + 1) - 1)
`endif

package inpkt_dispatch_ctrl_pkg;

    // Highest packet type the parser produces; keep in step with the parser.
    localparam int INPKT_MAX_TYPE   = 4;
    // Checksum bytes after the last data byte.
    localparam int INPKT_TRAIL_LEN  = 4;
    // Cycles from the last trailer byte to the parser's checksum verdict.
    localparam int INPKT_DONE_DELAY = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_TRAIL  = 3'd2,
        ST_PAUSED = 3'd3,
        ST_ERROR  = 3'd4
    } dispatch_state_t;

    // States in which a byte may be popped from the input FIFO. A pending
    // pause in IDLE wins over starting a new packet.
    function automatic logic state_can_accept(input dispatch_state_t s,
                                              input logic            pause);
        return ((s == ST_IDLE) && !pause) || (s == ST_HDR) || (s == ST_TRAIL);
    endfunction

endpackage

// File: rtl/inpkt_dispatch_ctrl_out_stage.sv
// One-entry registered output stage feeding the per-type destination FIFOs.
// The held byte is written to the destination of its type whenever that
// destination is not full; a new byte may load in the same cycle it drains.

module dispatch_out_stage #(
    parameter int NUM_TYPES = 4,
    parameter int TYPE_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [7:0]           load_data,
    input  logic [TYPE_W-1:0]    load_type,
    input  logic                 load_end,
    input  logic [NUM_TYPES-1:0] dest_full,
    output logic [7:0]           dest_din,
    output logic [NUM_TYPES-1:0] dest_wr_en,
    output logic                 dest_pkt_end,
    output logic                 out_free
);

    logic              out_valid_reg;
    logic [TYPE_W-1:0] out_type_reg;
    logic [7:0]        data_reg;
    logic              end_reg;
    logic              drain;

    // Type k lives on bit k-1; a write is gated by that destination's full flag.
    generate
        for (genvar gi = 0; gi < NUM_TYPES; gi++) begin : g_wr
            assign dest_wr_en[gi] = out_valid_reg
                                  & (out_type_reg == TYPE_W'(gi + 1))
                                  & ~dest_full[gi];
        end
    endgenerate

    assign drain        = |dest_wr_en;
    assign out_free     = ~out_valid_reg | drain;
    assign dest_din     = data_reg;
    assign dest_pkt_end = end_reg;

    // Hold register: load on request, stay valid until drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_type_reg  <= '0;
            data_reg      <= 8'h00;
            end_reg       <= 1'b0;
        end else begin
            if (load) begin
                data_reg     <= load_data;
                out_type_reg <= load_type;
                end_reg      <= load_end;
            end
            out_valid_reg <= load | (out_valid_reg & ~drain);
        end
    end

endmodule

// File: rtl/inpkt_dispatch_ctrl.sv
// Input packet dispatch controller: pops the FWFT input FIFO into the header
// parser, routes data bytes to per-type destinations, tracks packet
// boundaries for pause and statistics, and latches the first parser error.

module inpkt_dispatch_ctrl
    import inpkt_dispatch_ctrl_pkg::*;
#(
    parameter int PKT_MAX_TYPE = INPKT_MAX_TYPE,
    parameter int PKT_TYPE_MSB = `MSB(PKT_MAX_TYPE),
    parameter int TRAIL_LEN    = INPKT_TRAIL_LEN,
    parameter int DONE_DELAY   = INPKT_DONE_DELAY
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [7:0]              fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [7:0]              parser_din,
    output logic                    parser_wr_en,
    input  logic [PKT_TYPE_MSB:0]   parser_pkt_type,
    input  logic                    parser_pkt_data,
    input  logic                    parser_pkt_end,
    input  logic                    parser_err,
    input  logic [PKT_MAX_TYPE-1:0] type_en,
    input  logic                    pause,
    output logic [7:0]              dest_din,
    output logic [PKT_MAX_TYPE-1:0] dest_wr_en,
    input  logic [PKT_MAX_TYPE-1:0] dest_full,
    output logic                    dest_pkt_end,
    output logic                    paused,
    output logic                    err,
    output logic [15:0]             pkt_done_count,
    output logic [15:0]             pkt_drop_count
);

    localparam int TW  = PKT_TYPE_MSB + 1;
    localparam int TCW = $clog2(TRAIL_LEN + 1);

    dispatch_state_t       state_reg;
    logic [TCW-1:0]        trail_cnt_reg;
    logic                  drop_reg;
    logic                  paused_reg;
    logic                  err_reg;
    logic [DONE_DELAY-1:0] pipe_valid_reg;
    logic [DONE_DELAY-1:0] pipe_drop_reg;
    logic [15:0]           done_cnt_reg;
    logic [15:0]           drop_cnt_reg;

    logic type_on;
    logic out_free;
    logic accept;
    logic load;
    logic trail_last;
    logic launch;

    // Enable bit of the parser's current type; out-of-range types read as disabled.
    always_comb begin
        type_on = 1'b0;
        for (int k = 1; k <= PKT_MAX_TYPE; k++) begin
            if (parser_pkt_type == TW'(k)) type_on = type_en[k-1];
        end
    end

    // A data byte of an enabled type needs room in the output stage; all
    // other bytes (header, trailer, discarded data) go straight to the parser.
    assign accept = state_can_accept(state_reg, pause) & ~fifo_empty
                  & (~parser_pkt_data | ~type_on | out_free) & ~RESET;
    assign load         = accept & parser_pkt_data & type_on;
    assign fifo_rd_en   = accept;
    assign parser_wr_en = accept;
    assign parser_din   = fifo_dout;

    assign trail_last = (trail_cnt_reg == TCW'(TRAIL_LEN - 1));
    assign launch     = (state_reg == ST_TRAIL) & accept & trail_last;

    assign paused         = paused_reg;
    assign err            = err_reg;
    assign pkt_done_count = done_cnt_reg;
    assign pkt_drop_count = drop_cnt_reg;

    dispatch_out_stage #(
        .NUM_TYPES (PKT_MAX_TYPE),
        .TYPE_W    (TW)
    ) u_out (
        .clk          (CLK),
        .rst          (RESET),
        .load         (load),
        .load_data    (fifo_dout),
        .load_type    (parser_pkt_type),
        .load_end     (parser_pkt_end),
        .dest_full    (dest_full),
        .dest_din     (dest_din),
        .dest_wr_en   (dest_wr_en),
        .dest_pkt_end (dest_pkt_end),
        .out_free     (out_free)
    );

    // Packet-boundary sequencer with registered paused/err flags.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            trail_cnt_reg <= '0;
            drop_reg      <= 1'b0;
            paused_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else if (parser_err) begin
            state_reg  <= ST_ERROR;
            err_reg    <= 1'b1;
            paused_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pause) begin
                        state_reg  <= ST_PAUSED;
                        paused_reg <= 1'b1;
                    end else if (accept && (fifo_dout != 8'h00)) begin
                        state_reg <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (accept && parser_pkt_data && parser_pkt_end) begin
                        state_reg     <= ST_TRAIL;
                        trail_cnt_reg <= '0;
                        drop_reg      <= ~type_on;
                    end
                end
                ST_TRAIL: begin
                    if (accept) begin
                        if (trail_last) state_reg <= ST_IDLE;
                        else            trail_cnt_reg <= trail_cnt_reg + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_reg  <= ST_IDLE;
                        paused_reg <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    state_reg <= ST_ERROR;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Done pipe waits for the checksum verdict, then counts the packet.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pipe_valid_reg <= '0;
            pipe_drop_reg  <= '0;
            done_cnt_reg   <= 16'h0000;
            drop_cnt_reg   <= 16'h0000;
        end else begin
            pipe_valid_reg[0] <= launch;
            pipe_drop_reg[0]  <= drop_reg;
            for (int i = 1; i < DONE_DELAY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_drop_reg[i]  <= pipe_drop_reg[i-1];
            end
            if (pipe_valid_reg[DONE_DELAY-1] && !parser_err) begin
                if (pipe_drop_reg[DONE_DELAY-1]) drop_cnt_reg <= drop_cnt_reg + 16'd1;
                else                             done_cnt_reg <= done_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: doc/inpkt_dispatch_ctrl.md
Name: inpkt_dispatch_ctrl

Overview:
- Sequences the input packet header parser (inpkt_header).
- Pops bytes from the first-word-fall-through input FIFO and drives the parser's din and wr_en.
- Routes packet-data bytes to per-type destination FIFOs through one registered output stage, with backpressure.
- Tracks packet boundaries, so pause requests and statistics take effect only between packets.
- Latches the first parser error and holds until reset.

Parameters:
- PKT_MAX_TYPE, 4, highest valid packet type; must match the parser instance.
- PKT_TYPE_MSB, `MSB(PKT_MAX_TYPE), MSB of the type field.
- TRAIL_LEN, 4, checksum bytes that follow the last data byte.
- DONE_DELAY, 2, cycles from the last trailer byte to the parser's checksum verdict.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- fifo_dout  in  8  input FIFO data (FWFT)
- fifo_empty  in  1  input FIFO empty
- fifo_rd_en  out  1  pop input FIFO
- parser_din  out  8  byte to parser (= fifo_dout)
- parser_wr_en  out  1  parser write strobe (= fifo_rd_en)
- parser_pkt_type  in  PKT_TYPE_MSB+1  current type from parser
- parser_pkt_data  in  1  parser is in its data state
- parser_pkt_end  in  1  parser's current byte is the last data byte
- parser_err  in  1  parser error state
- type_en  in  PKT_MAX_TYPE  per-type enable; bit k-1 enables type k
- pause  in  1  request to stop at next packet boundary
- dest_din  out  8  registered data to destinations
- dest_wr_en  out  PKT_MAX_TYPE  one-hot write; bit k-1 for type k
- dest_full  in  PKT_MAX_TYPE  per-destination full
- dest_pkt_end  out  1  dest_din is the last byte of a packet
- paused  out  1  stopped at a boundary
- err  out  1  sticky error
- pkt_done_count  out  16  packets completed without error
- pkt_drop_count  out  16  completed packets of disabled type

Behaviour:
Reset and accept
- Reset values: all outputs 0; state IDLE; output stage empty; counters 0.
- Reset is asynchronous. fifo_rd_en and parser_wr_en are forced 0 while RESET is high.
- Parser has no reset input. Parser recovery from error requires the system-level reset; this block does not attempt it.
- out_free = ~out_valid | ~dest_full[out_type].
- accept = state in {IDLE, HDR, TRAIL} & ~fifo_empty & (~parser_pkt_data | ~type_en[parser_pkt_type] | out_free).
- fifo_rd_en = parser_wr_en = accept, combinational, same cycle. parser_din = fifo_dout.

Output stage
- On accept with parser_pkt_data=1 and the type enabled: register dest_din, out_type and dest_pkt_end (= parser_pkt_end); set out_valid.
- Latency: FIFO byte to dest_din is 1 cycle.
- dest_wr_en[k] = out_valid & out_type==k & ~dest_full[k].
- out_valid clears when its byte drains and no new byte loads. Load and drain may occur in the same cycle.
- Disabled types: data bytes are consumed and discarded.

State machine
- IDLE:
  - Accepting 0x00 stays in IDLE (parser skip).
  - Accepting a nonzero byte goes to HDR.
  - If pause=1 and the FIFO is empty or no byte is accepted, go to PAUSED. Pause has priority over accepting a new byte.
- HDR (header + data):
  - Accepting with parser_pkt_end=1 goes to TRAIL; trailer count is cleared.
- TRAIL:
  - Counts accepted bytes. After the TRAIL_LEN-th byte, go to IDLE and launch the done pipe.
- PAUSED:
  - paused=1, no accepts.
  - pause=0 returns to IDLE.
- ERROR:
  - Entered from any state when parser_err=1 (priority over all other transitions).
  - Sets err; no accepts; the output stage still drains.
  - Exit only by RESET.

Done pipe and counters
- Done pipe is a DONE_DELAY-deep shift carrying the drop flag.
- At its output, if parser_err=0: increment pkt_done_count, or pkt_drop_count when the packet type was disabled.
- Counters wrap at 0xFFFF without error.
- The parser may take one extra byte after a bad byte, before parser_err is seen. This is legal; the parser ignores it.

Decomposition:
- Shared package/header: state encodings, TRAIL_LEN, DONE_DELAY, `MSB macro. PKT_MAX_TYPE comes from the same constants the parser uses.
- One natural sub-module: dispatch_out_stage, the one-entry registered output with one-hot full-gated write.

Test Plan:
1. Type 1, len 3, id 0x0102, valid checksums, dest_full=0 → dest_wr_en=4'b0001 for 3 cycles, dest_pkt_end on byte 3, pkt_done_count=1 after DONE_DELAY.
2. Same packet with dest_full[0] held 1 for 5 cycles mid-data → no accepts during the stall; bytes arrive in order; none lost or duplicated.
3. Type 2 with type_en[1]=0 → dest_wr_en stays 0; FIFO fully drained; pkt_drop_count=1, pkt_done_count=0.
4. Version byte 0x05 (wrong) → err=1 within 2 cycles; fifo_rd_en=0 thereafter; counters unchanged.
5. Corrupted trailing checksum → err=1; pkt_done_count stays 0.
6. pause asserted mid-data → current packet completes including trailer; paused=1; next packet stays in FIFO. Deassert pause → it is processed. Also assert RESET mid-packet → all outputs return to 0 immediately.
